// File: rtl/edit_regs_if.sv
`default_nettype none
// ============================================================================
// Module      : edit_regs_if
// Description : Panel-side bus for the digit editor: sampled button levels,
//               parallel load port, and the registered cursor/digit/pulse
//               outputs seen by display and register consumers.
// Revision    : 1.0 - initial release
// ============================================================================
interface edit_regs_if #(
  parameter int NUM_DIGITS = 32,
  parameter int CURSOR_W   = 5,
  parameter int DIGIT_W    = 4
) ();

  logic                          slow_clock;
  logic                          incDigit;
  logic                          decDigit;
  logic                          incSelection;
  logic                          decSelection;
  logic                          load;
  logic [NUM_DIGITS*DIGIT_W-1:0] load_value;
  logic [CURSOR_W-1:0]           digit;
  logic [NUM_DIGITS*DIGIT_W-1:0] values;
  logic [NUM_DIGITS-1:0]         doInc;
  logic [NUM_DIGITS-1:0]         doDec;

  // Panel / stimulus side: drives buttons and load, observes editor state.
  modport master (
    output slow_clock, incDigit, decDigit, incSelection, decSelection,
    output load, load_value,
    input  digit, values, doInc, doDec
  );

  // Editor side.
  modport slave (
    input  slow_clock, incDigit, decDigit, incSelection, decSelection,
    input  load, load_value,
    output digit, values, doInc, doDec
  );

endinterface
`default_nettype wire

// File: rtl/edit_regs_gen.sv
`default_nettype none
// ============================================================================
// Module      : edit_regs_gen
// Description : Front-panel digit editor. Holds NUM_DIGITS radix-RADIX digits
//               and a cursor; buttons sampled on slow_clock ticks move the
//               cursor and inc/dec the selected digit with auto-repeat,
//               optional carry/borrow, and a saturating parallel load.
// Revision    : 1.0 - initial release
// ============================================================================
module edit_regs_gen #(
  parameter int NUM_DIGITS   = 32,
  parameter int CURSOR_W     = 5,
  parameter int RADIX        = 10,
  parameter int DIGIT_W      = 4,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 2,
  parameter int CARRY_EN     = 0
) (
  input  wire logic   clk,
  input  wire logic   reset,
  edit_regs_if.slave  bus
);

  localparam int C_CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);

  localparam logic [DIGIT_W-1:0]  C_MAX_DIGIT = DIGIT_W'(RADIX - 1);
  localparam logic [CURSOR_W-1:0] C_LAST_POS  = CURSOR_W'(NUM_DIGITS - 1);
  localparam logic [C_CNT_W-1:0]  C_DELAY     = C_CNT_W'(REPEAT_DELAY);
  localparam logic [C_CNT_W-1:0]  C_RATE      = C_CNT_W'(REPEAT_RATE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  // Button history, updated only on slow ticks.
  logic r_prev_inc_digit, r_prev_dec_digit;
  logic r_prev_inc_sel,   r_prev_dec_sel;

  logic [CURSOR_W-1:0]   r_cursor;
  logic [DIGIT_W-1:0]    r_vals [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] r_do_inc, r_do_dec;

  state_t               r_state, w_state_nx;
  logic [C_CNT_W-1:0]   r_cnt, w_cnt_nx, w_cnt_inc;
  logic                 r_dir, w_dir_nx;    // stored direction: 1 = decrement

  logic w_inc_press, w_dec_press, w_both_sel, w_stored_held;
  logic w_mv_up, w_mv_dn;
  logic w_edit, w_edit_dec, w_carry;
  logic [DIGIT_W-1:0]    w_vals_nx [NUM_DIGITS];
  logic [DIGIT_W-1:0]    w_load_sat [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] w_onehot;
  logic [NUM_DIGITS*DIGIT_W-1:0] w_values_packed;

  assign w_inc_press   = bus.incSelection & ~r_prev_inc_sel;
  assign w_dec_press   = bus.decSelection & ~r_prev_dec_sel;
  assign w_both_sel    = bus.incSelection & bus.decSelection;
  assign w_stored_held = r_dir ? bus.decSelection : bus.incSelection;
  assign w_mv_up       = bus.slow_clock & bus.incDigit & ~r_prev_inc_digit;
  assign w_mv_dn       = bus.slow_clock & bus.decDigit & ~r_prev_dec_digit;
  assign w_cnt_inc     = r_cnt + C_CNT_W'(1);
  assign w_onehot      = NUM_DIGITS'(1) << r_cursor;

  // Capture button levels on each slow tick for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_inc_digit <= 1'b0;
      r_prev_dec_digit <= 1'b0;
      r_prev_inc_sel   <= 1'b0;
      r_prev_dec_sel   <= 1'b0;
    end else if (bus.slow_clock) begin
      r_prev_inc_digit <= bus.incDigit;
      r_prev_dec_digit <= bus.decDigit;
      r_prev_inc_sel   <= bus.incSelection;
      r_prev_dec_sel   <= bus.decSelection;
    end
  end

  // Cursor moves on a single press edge; simultaneous presses cancel.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cursor <= '0;
    end else if (w_mv_up && !w_mv_dn) begin
      r_cursor <= (r_cursor == C_LAST_POS) ? '0 : r_cursor + CURSOR_W'(1);
    end else if (w_mv_dn && !w_mv_up) begin
      r_cursor <= (r_cursor == '0) ? C_LAST_POS : r_cursor - CURSOR_W'(1);
    end
  end

  // Repeat FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_dir   <= w_dir_nx;
    end
  end

  // Repeat FSM next state and edit request; a released stored button falls
  // through to the press checks so an opposite press starts a new sequence.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_dir_nx   = r_dir;
    w_edit     = 1'b0;
    w_edit_dec = r_dir;
    if (bus.slow_clock) begin
      if (w_both_sel) begin
        w_state_nx = S_IDLE;
      end else if (r_state != S_IDLE && w_stored_held) begin
        if (r_state == S_HOLD && w_cnt_inc == C_DELAY) begin
          w_edit     = 1'b1;
          w_cnt_nx   = '0;
          w_state_nx = S_REPEAT;
        end else if (r_state == S_REPEAT && w_cnt_inc == C_RATE) begin
          w_edit     = 1'b1;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx   = w_cnt_inc;
        end
      end else if (w_inc_press) begin
        w_edit     = 1'b1;
        w_edit_dec = 1'b0;
        w_dir_nx   = 1'b0;
        w_cnt_nx   = '0;
        w_state_nx = S_HOLD;
      end else if (w_dec_press) begin
        w_edit     = 1'b1;
        w_edit_dec = 1'b1;
        w_dir_nx   = 1'b1;
        w_cnt_nx   = '0;
        w_state_nx = S_HOLD;
      end else begin
        w_state_nx = S_IDLE;
      end
    end
  end

  // Edit datapath: modify the cursor digit, then ripple wraps upward when
  // carry is enabled; a wrap out of the top digit is simply lost.
  always_comb begin
    w_vals_nx = r_vals;
    w_carry   = 1'b0;
    if (w_edit) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (i == int'(r_cursor) ||
            (CARRY_EN != 0 && w_carry && i > int'(r_cursor))) begin
          if (w_edit_dec) begin
            w_carry      = (r_vals[i] == '0);
            w_vals_nx[i] = w_carry ? C_MAX_DIGIT : r_vals[i] - DIGIT_W'(1);
          end else begin
            w_carry      = (r_vals[i] == C_MAX_DIGIT);
            w_vals_nx[i] = w_carry ? '0 : r_vals[i] + DIGIT_W'(1);
          end
        end
      end
    end
  end

  // Load data with out-of-range fields clamped to the largest legal digit.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_load_sat[i] = (32'(bus.load_value[i*DIGIT_W +: DIGIT_W]) >= RADIX)
                      ? C_MAX_DIGIT : bus.load_value[i*DIGIT_W +: DIGIT_W];
    end
  end

  // Digit registers and edit pulses; load overrides any same-cycle edit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vals   <= '{default: '0};
      r_do_inc <= '0;
      r_do_dec <= '0;
    end else if (bus.load) begin
      r_vals   <= w_load_sat;
      r_do_inc <= '0;
      r_do_dec <= '0;
    end else begin
      r_vals   <= w_vals_nx;
      r_do_inc <= (w_edit && !w_edit_dec) ? w_onehot : '0;
      r_do_dec <= (w_edit &&  w_edit_dec) ? w_onehot : '0;
    end
  end

  // Flatten digit registers onto the packed output bus.
  always_comb begin
    w_values_packed = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_values_packed[i*DIGIT_W +: DIGIT_W] = r_vals[i];
    end
  end

  assign bus.values = w_values_packed;
  assign bus.digit  = r_cursor;
  assign bus.doInc  = r_do_inc;
  assign bus.doDec  = r_do_dec;

endmodule
`default_nettype wire

// File: tb/tb_edit_regs_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_edit_regs_gen
// Description : Scoreboard bench for edit_regs_gen. Two instances (carry off
//               and carry on) share one stimulus stream; a digit-list model
//               predicts every cycle's outputs, a negedge monitor compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_edit_regs_gen;

  localparam int ND   = 32;
  localparam int DW   = 4;
  localparam int RAD  = 10;
  localparam int DEL  = 8;
  localparam int RATE = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  edit_regs_if #(.NUM_DIGITS(ND), .CURSOR_W(5), .DIGIT_W(DW)) if_a ();
  edit_regs_if #(.NUM_DIGITS(ND), .CURSOR_W(5), .DIGIT_W(DW)) if_b ();

  edit_regs_gen #(
    .NUM_DIGITS(ND), .CURSOR_W(5), .RADIX(RAD), .DIGIT_W(DW),
    .REPEAT_DELAY(DEL), .REPEAT_RATE(RATE), .CARRY_EN(0)
  ) dut_a (.clk(clk), .reset(rst), .bus(if_a.slave));

  edit_regs_gen #(
    .NUM_DIGITS(ND), .CURSOR_W(5), .RADIX(RAD), .DIGIT_W(DW),
    .REPEAT_DELAY(DEL), .REPEAT_RATE(RATE), .CARRY_EN(1)
  ) dut_b (.clk(clk), .reset(rst), .bus(if_b.slave));

  typedef struct {
    logic [ND*DW-1:0] va;
    logic [ND*DW-1:0] vb;
    logic [4:0]       dg;
    logic [ND-1:0]    di;
    logic [ND-1:0]    dd;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;

  int n_total = 0;
  int n_pass  = 0;

  // Stimulus levels
  bit d_rst, d_slow, d_incD, d_decD, d_incS, d_decS, d_load;
  logic [ND*DW-1:0] d_lv;

  // Reference model: digits as integer lists, hold tracked as ticks held
  int ma[ND];
  int mb[ND];
  int m_cur, m_held, m_ht;   // m_held: 0 none, 1 inc, 2 dec
  bit m_pid, m_pdd, m_pis, m_pds;
  logic [ND-1:0] m_di, m_dd;

  function automatic void chk(string nm, logic [ND*DW-1:0] act, logic [ND*DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endfunction

  // Adds or subtracts one at pos; with carry, wraps continue upward.
  task automatic edit_one(input bit use_b, input bit dec, input int pos);
    int a[ND];
    bit wrap;
    a = use_b ? mb : ma;
    for (int i = pos; i < ND; i++) begin
      if (dec) begin
        wrap = (a[i] == 0);
        a[i] = wrap ? RAD - 1 : a[i] - 1;
      end else begin
        wrap = (a[i] == RAD - 1);
        a[i] = wrap ? 0 : a[i] + 1;
      end
      if (!(use_b && wrap)) break;
    end
    if (use_b) mb = a; else ma = a;
  endtask

  task automatic model_step();
    int ed;
    int old;
    int f;
    bit ip, dp, mu, md, sh;
    exp_t x;
    ed  = 0;
    old = m_cur;
    if (d_rst) begin
      for (int i = 0; i < ND; i++) begin ma[i] = 0; mb[i] = 0; end
      m_cur = 0; m_held = 0; m_ht = 0;
      m_pid = 0; m_pdd = 0; m_pis = 0; m_pds = 0;
      m_di = '0; m_dd = '0;
    end else begin
      if (d_slow) begin
        ip = d_incS && !m_pis;
        dp = d_decS && !m_pds;
        mu = d_incD && !m_pid;
        md = d_decD && !m_pdd;
        if (mu && !md)      m_cur = (m_cur + 1) % ND;
        else if (md && !mu) m_cur = (m_cur + ND - 1) % ND;
        sh = (m_held == 1 && d_incS) || (m_held == 2 && d_decS);
        if (d_incS && d_decS) begin
          m_held = 0;
        end else if (sh) begin
          m_ht++;
          if (m_ht == DEL || (m_ht > DEL && (m_ht - DEL) % RATE == 0)) ed = m_held;
        end else if (ip) begin
          m_held = 1; m_ht = 0; ed = 1;
        end else if (dp) begin
          m_held = 2; m_ht = 0; ed = 2;
        end else begin
          m_held = 0;
        end
        m_pid = d_incD; m_pdd = d_decD; m_pis = d_incS; m_pds = d_decS;
      end
      m_di = '0;
      m_dd = '0;
      if (d_load) begin
        for (int i = 0; i < ND; i++) begin
          f = int'(d_lv[i*DW +: DW]);
          ma[i] = (f >= RAD) ? RAD - 1 : f;
          mb[i] = ma[i];
        end
      end else if (ed != 0) begin
        edit_one(1'b0, ed == 2, old);
        edit_one(1'b1, ed == 2, old);
        if (ed == 1) m_di[old] = 1'b1; else m_dd[old] = 1'b1;
      end
    end
    for (int i = 0; i < ND; i++) begin
      x.va[i*DW +: DW] = DW'(ma[i]);
      x.vb[i*DW +: DW] = DW'(mb[i]);
    end
    x.dg = 5'(m_cur);
    x.di = m_di;
    x.dd = m_dd;
    sb.push_back(x);
  endtask

  task automatic drive();
    rst = d_rst;
    if_a.slow_clock = d_slow;   if_b.slow_clock = d_slow;
    if_a.incDigit = d_incD;     if_b.incDigit = d_incD;
    if_a.decDigit = d_decD;     if_b.decDigit = d_decD;
    if_a.incSelection = d_incS; if_b.incSelection = d_incS;
    if_a.decSelection = d_decS; if_b.decSelection = d_decS;
    if_a.load = d_load;         if_b.load = d_load;
    if_a.load_value = d_lv;     if_b.load_value = d_lv;
  endtask

  // One clock: apply levels, predict the post-edge outputs, queue them.
  task automatic cyc();
    drive();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Two off-tick cycles with scrambled buttons, then a tick with given levels.
  task automatic tick(input bit id, input bit dd, input bit is, input bit ds);
    for (int k = 0; k < 2; k++) begin
      d_slow = 1'b0;
      d_incD = 1'($urandom); d_decD = 1'($urandom);
      d_incS = 1'($urandom); d_decS = 1'($urandom);
      cyc();
    end
    d_slow = 1'b1;
    d_incD = id; d_decD = dd; d_incS = is; d_decS = ds;
    cyc();
    d_slow = 1'b0;
  endtask

  // Compare each predicted cycle against both instances.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e_mon = sb.pop_front();
      chk("values_a", if_a.values, e_mon.va);
      chk("values_b", if_b.values, e_mon.vb);
      chk("digit_a",  ND*DW'(if_a.digit), ND*DW'(e_mon.dg));
      chk("digit_b",  ND*DW'(if_b.digit), ND*DW'(e_mon.dg));
      chk("doInc_a",  ND*DW'(if_a.doInc), ND*DW'(e_mon.di));
      chk("doInc_b",  ND*DW'(if_b.doInc), ND*DW'(e_mon.di));
      chk("doDec_a",  ND*DW'(if_a.doDec), ND*DW'(e_mon.dd));
      chk("doDec_b",  ND*DW'(if_b.doDec), ND*DW'(e_mon.dd));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    d_rst = 1; d_slow = 0; d_incD = 0; d_decD = 0; d_incS = 0; d_decS = 0;
    d_load = 0; d_lv = '0;
    m_cur = 0; m_held = 0; m_ht = 0;
    // reset, with incSelection held through it
    d_incS = 1;
    repeat (3) cyc();
    d_rst = 0;
    // held-through-reset press, release, then a clean press/release
    tick(0, 0, 1, 0); tick(0, 0, 0, 0);
    tick(0, 0, 1, 0); tick(0, 0, 0, 0);
    // cursor wrap up to 31, then 0, back to 31, then 0
    repeat (32) begin tick(1, 0, 0, 0); tick(0, 0, 0, 0); end
    tick(0, 1, 0, 0); tick(0, 0, 0, 0);
    tick(1, 0, 0, 0); tick(0, 0, 0, 0);
    tick(1, 1, 0, 0); tick(0, 0, 0, 0);
    // auto-repeat from zero: 14 held ticks
    d_load = 1; d_lv = '0; cyc(); d_load = 0;
    repeat (14) tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    // carry / borrow at cursor 0
    d_load = 1; d_lv = '0; d_lv[3:0] = 4'd9; d_lv[7:4] = 4'd9; d_lv[11:8] = 4'd3;
    cyc(); d_load = 0;
    tick(0, 0, 1, 0); tick(0, 0, 0, 0);
    tick(0, 0, 0, 1); tick(0, 0, 0, 0);
    // saturating load colliding with an increment press
    d_load = 1; d_lv = '1; d_slow = 1;
    d_incD = 0; d_decD = 0; d_incS = 1; d_decS = 0;
    cyc();
    d_load = 0; d_slow = 0;
    tick(0, 0, 0, 0);
    // both selection buttons, then opposite-press handover
    tick(0, 0, 1, 1); tick(0, 0, 0, 0);
    tick(0, 0, 1, 0); tick(0, 0, 0, 1); tick(0, 0, 0, 0);
    // reset during HOLD
    tick(0, 0, 1, 0); tick(0, 0, 1, 0);
    d_rst = 1; cyc(); d_rst = 0; cyc();
    tick(0, 0, 0, 0);
    // randomized run
    for (int n = 0; n < 4000; n++) begin
      d_rst  = ($urandom_range(399, 0) == 0);
      d_slow = ($urandom_range(2, 0) == 0);
      if ($urandom_range(7, 0) == 0)  d_incD = !d_incD;
      if ($urandom_range(7, 0) == 0)  d_decD = !d_decD;
      if ($urandom_range(15, 0) == 0) d_incS = !d_incS;
      if ($urandom_range(15, 0) == 0) d_decS = !d_decS;
      d_load = ($urandom_range(49, 0) == 0);
      if (d_load) for (int i = 0; i < 4; i++) d_lv[i*32 +: 32] = $urandom;
      cyc();
    end
    d_rst = 0; d_load = 0; d_slow = 0;
    cyc();
    @(negedge clk);
    #1;
    chk("scoreboard_drained", ND*DW'(sb.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
